iccm_dump_ctrl: RTL and testbench

ICCM_DUMP_CTRL -- requirements
Module: iccm_dump_ctrl

---
 rtl/iccm_dump_if.sv | 21 ++
 rtl/iccm_dump_ctrl.sv | 148 ++++++++++++++
 tb/tb_iccm_dump_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/iccm_dump_if.sv
// ICCM read port plus UART transmit handshake used by iccm_dump_ctrl.
// master: the dump controller; slave: the ICCM/UART side.
interface iccm_dump_if;
    logic        re_o;
    logic [11:0] addr_o;
    logic [31:0] rdata_i;
    logic        tx_dv_o;
    logic [7:0]  tx_byte_o;
    logic        tx_busy_i;
    logic        tx_done_i;

    modport master (
        output re_o, addr_o, tx_dv_o, tx_byte_o,
        input  rdata_i, tx_busy_i, tx_done_i
    );

    modport slave (
        input  re_o, addr_o, tx_dv_o, tx_byte_o,
        output rdata_i, tx_busy_i, tx_done_i
    );
endinterface

// File: rtl/iccm_dump_ctrl.sv
// ICCM dump controller: reads len_i words from address 0 and streams each
// word MSB-first as four bytes over a UART transmit handshake.
// Optional macro ICCM_DUMP_TERM_EN appends the terminator bytes 00 00 0F FF.
module iccm_dump_ctrl (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [11:0] len_i,
    output logic        busy_o,
    output logic        done_o,
    iccm_dump_if.master bus
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StLatch,
        StSend,
        StWaitTx,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] addr_q, addr_d;
    logic [11:0] len_q, len_d;
    logic [11:0] word_cnt_q, word_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] word_q, word_d;
`ifdef ICCM_DUMP_TERM_EN
    localparam logic [31:0] TermWord = 32'h0000_0FFF;
    // Set while the terminator word is being streamed instead of ICCM data.
    logic        term_q, term_d;
`endif

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
`ifdef ICCM_DUMP_TERM_EN
            term_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
`ifdef ICCM_DUMP_TERM_EN
            term_q     <= term_d;
`endif
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
`ifdef ICCM_DUMP_TERM_EN
        term_d     = term_q;
`endif
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    len_d      = len_i;
                    addr_d     = '0;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    if (len_i != 12'd0) begin
                        state_d = StRead;
                    end else begin
`ifdef ICCM_DUMP_TERM_EN
                        word_d  = TermWord;
                        term_d  = 1'b1;
                        state_d = StSend;
`else
                        state_d = StDone;
`endif
                    end
                end
            end
            StRead:  state_d = StLatch;
            StLatch: begin
                word_d     = bus.rdata_i;
                byte_cnt_d = '0;
                state_d    = StSend;
            end
            StSend: begin
                if (!bus.tx_busy_i) state_d = StWaitTx;
            end
            StWaitTx: begin
                if (bus.tx_done_i) begin
                    if (byte_cnt_q != 2'd3) begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        state_d    = StSend;
`ifdef ICCM_DUMP_TERM_EN
                    end else if (term_q) begin
                        term_d  = 1'b0;
                        state_d = StDone;
`endif
                    end else begin
                        addr_d     = addr_q + 12'd1;
                        word_cnt_d = word_cnt_q + 12'd1;
                        byte_cnt_d = '0;
                        if (word_cnt_d == len_q) begin
`ifdef ICCM_DUMP_TERM_EN
                            word_d  = TermWord;
                            term_d  = 1'b1;
                            state_d = StSend;
`else
                            state_d = StDone;
`endif
                        end else begin
                            state_d = StRead;
                        end
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state; the byte mux is held by the unchanged counter.
    always_comb begin
        bus.re_o    = (state_q == StRead);
        bus.addr_o  = addr_q;
        bus.tx_dv_o = (state_q == StSend) && !bus.tx_busy_i;
        case (byte_cnt_q)
            2'd0:    bus.tx_byte_o = word_q[31:24];
            2'd1:    bus.tx_byte_o = word_q[23:16];
            2'd2:    bus.tx_byte_o = word_q[15:8];
            default: bus.tx_byte_o = word_q[7:0];
        endcase
        busy_o = (state_q != StIdle);
        done_o = (state_q == StDone);
    end

endmodule

// File: tb/tb_iccm_dump_ctrl.sv
// Scoreboard bench for iccm_dump_ctrl with ICCM and UART transmitter models.
module tb_iccm_dump_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [11:0] len_i;
    logic        busy_o;
    logic        done_o;

    iccm_dump_if bus ();

    iccm_dump_ctrl dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .len_i   (len_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;
    logic [31:0] mem [4096];
    logic [7:0]  exp_bytes [$];
    logic [11:0] exp_addrs [$];
    int          exp_done = 0;
    int          bytes_seen = 0;
    bit          repulse_en = 0;
    bit          spur_en = 0;
    bit          busy_en = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endfunction

    function automatic void fail(string name);
        total++;
        bad++;
        $display("FAIL %s: got event, want none", name);
    endfunction

    // ICCM and UART transmitter models.
    initial begin
        int          tx_cnt;
        int          extra_cnt;
        logic        model_busy;
        logic        s_dv;
        logic        s_re;
        logic [11:0] s_addr;
        tx_cnt = 0;
        extra_cnt = 0;
        model_busy = 0;
        bus.rdata_i = '0;
        bus.tx_busy_i = 0;
        bus.tx_done_i = 0;
        forever begin
            @(negedge clk_i);
            s_dv = bus.tx_dv_o;
            s_re = bus.re_o;
            s_addr = bus.addr_o;
            @(posedge clk_i);
            #1;
            if (!rst_ni) begin
                tx_cnt = 0;
                model_busy = 0;
                s_dv = 0;
                s_re = 0;
            end
            // Read data is valid only in the cycle after re_o; garbage otherwise.
            bus.rdata_i = s_re ? mem[s_addr] : $urandom;
            bus.tx_done_i = 0;
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    bus.tx_done_i = 1;
                    model_busy = 0;
                end
            end
            if (s_dv) begin
                model_busy = 1;
                tx_cnt = 3;
            end else if (tx_cnt == 0 && !bus.tx_done_i && spur_en && $urandom_range(0, 3) == 0) begin
                bus.tx_done_i = 1;
            end
            if (extra_cnt > 0) extra_cnt--;
            else if (busy_en && $urandom_range(0, 15) == 0) extra_cnt = 10;
            bus.tx_busy_i = model_busy || (extra_cnt > 0);
        end
    end

    // Monitor: compares every DUT output event against the scoreboard.
    initial begin
        logic       holding;
        logic [7:0] held;
        holding = 0;
        held = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                holding = 0;
            end else begin
                if (holding) begin
                    check("tx_byte_hold", 32'(bus.tx_byte_o), 32'(held));
                    if (bus.tx_done_i) holding = 0;
                end
                if (bus.tx_dv_o) begin
                    check("dv_while_busy", 32'(bus.tx_busy_i), 32'd0);
                    if (exp_bytes.size() == 0) fail("unexpected_tx_dv");
                    else check("tx_byte", 32'(bus.tx_byte_o), 32'(exp_bytes.pop_front()));
                    held = bus.tx_byte_o;
                    holding = 1;
                    bytes_seen++;
                end
                if (bus.re_o) begin
                    if (exp_addrs.size() == 0) fail("unexpected_re");
                    else check("re_addr", 32'(bus.addr_o), 32'(exp_addrs.pop_front()));
                end
                if (done_o) begin
                    if (exp_done == 0) begin
                        fail("unexpected_done");
                    end else begin
                        exp_done--;
                        check("done_bytes_left", 32'(exp_bytes.size()), 32'd0);
                        check("done_reads_left", 32'(exp_addrs.size()), 32'd0);
                        check("done_busy", 32'(busy_o), 32'd1);
                    end
                end
            end
        end
    end

    // Reference: word w is read from address w, then sent as bytes 31:24 down to 7:0.
    task automatic start_dump(input logic [11:0] len);
        logic [31:0] wd;
        for (int w = 0; w < int'(len); w++) begin
            exp_addrs.push_back(w[11:0]);
            wd = mem[w];
            for (int b = 0; b < 4; b++) exp_bytes.push_back(wd[31 - 8 * b -: 8]);
        end
`ifdef ICCM_DUMP_TERM_EN
        exp_bytes.push_back(8'h00);
        exp_bytes.push_back(8'h00);
        exp_bytes.push_back(8'h0F);
        exp_bytes.push_back(8'hFF);
`endif
        exp_done++;
        @(posedge clk_i);
        #1;
        start_i = 1;
        len_i = len;
        @(posedge clk_i);
        #1;
        start_i = 0;
        len_i = 12'($urandom);
`ifndef ICCM_DUMP_TERM_EN
        if (len == 12'd0) check("len0_done_next_cycle", 32'(done_o), 32'd1);
`endif
    endtask

    task automatic wait_done(input int limit);
        int c = 0;
        while (exp_done != 0 && c < limit) begin
            @(posedge clk_i);
            #1;
            if (repulse_en) begin
                start_i = 1'($urandom_range(0, 1));
                len_i = 12'($urandom);
            end
            c++;
        end
        start_i = 0;
        if (exp_done != 0) begin
            fail("dump_timeout");
            exp_bytes.delete();
            exp_addrs.delete();
            exp_done = 0;
        end
        @(posedge clk_i);
        #1;
        check("idle_after_done", 32'(busy_o), 32'd0);
    endtask

    task automatic run_dump(input logic [11:0] len);
        start_dump(len);
        wait_done(300 + 80 * int'(len));
    endtask

    initial begin
        int c;
        rst_ni = 0;
        start_i = 0;
        len_i = '0;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_re", 32'(bus.re_o), 32'd0);
        check("rst_addr", 32'(bus.addr_o), 32'd0);
        check("rst_dv", 32'(bus.tx_dv_o), 32'd0);
        check("rst_byte", 32'(bus.tx_byte_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        rst_ni = 1;

        mem[0] = 32'hDEADBEEF;
        run_dump(12'd1);
        mem[0] = 32'h11223344;
        mem[1] = 32'h55667788;
        run_dump(12'd2);
        run_dump(12'd0);

        // Reset during a three-word dump, after the second byte.
        c = bytes_seen;
        start_dump(12'd3);
        for (int i = 0; i < 200 && bytes_seen < c + 2; i++) @(negedge clk_i);
        if (bytes_seen < c + 2) fail("mid_dump_timeout");
        @(posedge clk_i);
        #2;
        rst_ni = 0;
        #1;
        check("abort_re", 32'(bus.re_o), 32'd0);
        check("abort_addr", 32'(bus.addr_o), 32'd0);
        check("abort_dv", 32'(bus.tx_dv_o), 32'd0);
        check("abort_byte", 32'(bus.tx_byte_o), 32'd0);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        exp_bytes.delete();
        exp_addrs.delete();
        exp_done = 0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1;
        repeat (30) @(posedge clk_i);
        run_dump(12'd3);

        // Randomised dumps with busy stretches, spurious done pulses and start re-pulses.
        busy_en = 1;
        spur_en = 1;
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 16; i++) mem[i] = $urandom;
            repulse_en = ($urandom_range(0, 1) == 1);
            run_dump(12'($urandom_range(0, 8)));
            repulse_en = 0;
        end
        busy_en = 0;
        spur_en = 0;
        repeat (10) @(posedge clk_i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
